ddr3_custom_read: RTL and testbench
===================================

Name: ddr3_custom_read

Overview:
- AXI3/AXI4 read master that fetches `read_ops` strided bursts from DDR3 through the PS/MIG port of one engine.
- Returned beats are forwarded to the downstream compute pipeline as a valid/ready stream.
- Read-side counterpart of the engine's custom DDR3 writer; it shares that writer's address map and burst-size convention.
- Sits between the engine control registers and the AXI HP port.

Parameters:
- ENGINE_ID, 0, engine index; placed in address bits [31:28].
- ADDR_WIDTH, 33, AXI byte-address width.
- DATA_WIDTH, 256, AXI data width; only 256 or 512 are legal.
- ID_WIDTH, 5, AXI ID width.
- MAX_OUTSTANDING, 4, maximum accepted AR bursts whose RLAST has not yet returned (1..15).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start_read  in  1  single-cycle start pulse; honoured only in IDLE.
- read_ops  in  32  number of bursts to read.
- stride  in  32  byte offset between consecutive burst addresses.
- init_addr  in  ADDR_WIDTH  base address; only bits [27:0] are used.
- mem_burst_size  in  16  bytes per burst; must be a multiple of DATA_WIDTH/8 and at most 256 beats.
- busy  out  1  high from the start cycle until done.
- done  out  1  one-cycle pulse when the last beat is delivered.
- rd_err  out  1  sticky error flag; cleared by start_read.
- dn_vld  out  1  downstream data valid.
- dn_dat  out  DATA_WIDTH  downstream data.
- dn_last  out  1  marks the last beat of each burst.
- dn_rdy  in  1  downstream ready.
- m_axi_ARVALID  out  1  read-address valid.
- m_axi_ARADDR  out  ADDR_WIDTH  read-address byte address.
- m_axi_ARID  out  ID_WIDTH  read-address ID.
- m_axi_ARLEN  out  8  burst length minus one.
- m_axi_ARSIZE  out  3  beat size.
- m_axi_ARBURST  out  2  burst type.
- m_axi_ARLOCK  out  2  lock type.
- m_axi_ARCACHE  out  4  cache attributes.
- m_axi_ARPROT  out  3  protection attributes.
- m_axi_ARQOS  out  4  QoS value.
- m_axi_ARREGION  out  4  region identifier.
- m_axi_ARREADY  in  1  read-address ready.
- m_axi_RVALID  in  1  read-data valid.
- m_axi_RDATA  in  DATA_WIDTH  read data.
- m_axi_RRESP  in  2  read response.
- m_axi_RLAST  in  1  last beat of the burst.
- m_axi_RID  in  ID_WIDTH  read ID.
- m_axi_RREADY  out  1  read-data ready.

Behaviour:
- Reset values:
  - ARVALID=0, ARADDR=0, busy=0, done=0, rd_err=0.
  - All counters 0, state IDLE.
  - Reset asserted mid-operation aborts immediately. Beats still in flight from the interconnect are the system's concern; no done pulse is issued.
- Static AR fields, registered:
  - ARID=0, ARBURST=01 (INCR), ARLOCK=0, ARCACHE=0000, ARPROT=010, ARQOS=0, ARREGION=0.
  - ARSIZE=101 for 256-bit, 110 for 512-bit.
  - ARLEN = mem_burst_size/(DATA_WIDTH/8) - 1, latched at start.
- Latching: read_ops, stride and the base address {1'b0, ENGINE_ID[3:0], init_addr[27:0]} are latched on start_read.
- FSM:
  - IDLE: on start_read, clear counters and rd_err, busy<=1. If read_ops==0, go to FIN; otherwise go to ISSUE.
  - ISSUE:
    - ARVALID=1 while outstanding < MAX_OUTSTANDING and ar_cnt < read_ops.
    - ARADDR = base + ar_cnt*stride (running accumulator, wraps modulo 2^ADDR_WIDTH).
    - ARADDR and ARVALID stay stable until ARREADY.
    - On handshake: ar_cnt++, outstanding++. When ar_cnt reaches read_ops, go to DRAIN.
  - DRAIN: ARVALID=0; wait until r_cnt==read_ops, then go to FIN.
  - FIN: done=1 for one cycle, busy<=0, return to IDLE.
- R path (zero-latency pass-through):
  - dn_vld=RVALID & busy, dn_dat=RDATA, dn_last=RLAST.
  - RREADY=dn_rdy & busy.
  - On RVALID&RREADY: increment beat_cnt.
  - On RLAST: r_cnt++, outstanding--, beat_cnt<=0.
- Simultaneous AR handshake and RLAST handshake: outstanding is unchanged.
- Error: rd_err<=1 on a handshaken beat with RRESP!=00, or RLAST != (beat_cnt==ARLEN). rd_err holds until the next start_read.
- start_read while not IDLE is ignored.

Optional Feature:
- Macro: DDR3_CUSTOM_READ_CKSUM_EN.
- Defined:
  - Adds output cksum [31:0], the XOR of all 32-bit lanes of every handshaken beat.
  - Cleared on start, valid when done pulses.
- Undefined: port absent, no logic added.

Test Plan:
- read_ops=4, stride=0x400, burst=256B, DATA_WIDTH=256, ENGINE_ID=2, init_addr=0x100, dn_rdy=1 -> ARADDR 0x20000100/500/900/D00, ARLEN=7, 32 beats, dn_last every 8th beat, done pulse once, rd_err=0.
- MAX_OUTSTANDING=2, slave withholds R for 50 cycles -> exactly 2 AR handshakes, ARVALID low until the first RLAST.
- dn_rdy toggled at 50% -> RREADY mirrors dn_rdy, no beat lost, total beats=32.
- RRESP=10 on beat 3; separately, RLAST early at beat 5 -> rd_err=1 stays set after done, cleared by the next start_read.
- read_ops=0 -> no ARVALID, done one cycle after start; rst pulsed mid-ISSUE -> ARVALID drops asynchronously, busy=0, no done.
- CKSUM_EN defined, one burst of known beats -> cksum equals the precomputed XOR.

Source files
------------

// File: rtl/ddr3_custom_read.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_custom_read
// Purpose  : AXI3/AXI4 read master. Fetches read_ops strided bursts from DDR3
//            through one engine's HP port. Returned beats are forwarded to the
//            downstream compute pipeline as a zero-latency valid/ready stream.
// Ports    : clk/rst (async, active-high)
//            start_read/read_ops/stride/init_addr/mem_burst_size - job setup
//            busy/done/rd_err                                     - status
//            dn_vld/dn_dat/dn_last/dn_rdy                         - downstream
//            m_axi_AR* / m_axi_R*                                 - AXI read
//            cksum (only with DDR3_CUSTOM_READ_CKSUM_EN defined)  - XOR of all
//            32-bit lanes of every delivered beat, valid with done
// Options  : define DDR3_CUSTOM_READ_CKSUM_EN to add the cksum output.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_custom_read #(
  parameter int ENGINE_ID       = 0,
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_read,
  input  logic [31:0]           read_ops,
  input  logic [31:0]           stride,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [15:0]           mem_burst_size,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_err,
  output logic                  dn_vld,
  output logic [DATA_WIDTH-1:0] dn_dat,
  output logic                  dn_last,
  input  logic                  dn_rdy,
  output logic                  m_axi_ARVALID,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  output logic [7:0]            m_axi_ARLEN,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  output logic [1:0]            m_axi_ARLOCK,
  output logic [3:0]            m_axi_ARCACHE,
  output logic [2:0]            m_axi_ARPROT,
  output logic [3:0]            m_axi_ARQOS,
  output logic [3:0]            m_axi_ARREGION,
  input  logic                  m_axi_ARREADY,
  input  logic                  m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic [1:0]            m_axi_RRESP,
  input  logic                  m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  output logic                  m_axi_RREADY
`ifdef DDR3_CUSTOM_READ_CKSUM_EN
  ,
  output logic [31:0]           cksum
`endif
);

  localparam int         C_BEAT_SHIFT = (DATA_WIDTH == 512) ? 6 : 5;
  localparam logic [2:0] C_AR_SIZE    = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
  localparam logic [3:0] C_ENG_NIB    = 4'(ENGINE_ID);
  localparam logic [3:0] C_MAX_OUT    = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_err_q, rd_err_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [31:0]           ops_q, ops_d;
  logic [31:0]           stride_q, stride_d;
  logic [31:0]           ar_cnt_q, ar_cnt_d;
  logic [31:0]           r_cnt_q, r_cnt_d;
  logic [3:0]            outst_q, outst_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;

  logic                  w_rready;
  logic                  w_r_hs;
  logic                  w_r_last_hs;
  logic                  w_ar_hs;
  logic [15:0]           w_beats;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  unused_ok;

  // Engine index lives in bits [31:28]; only the low 28 bits of init_addr count.
  assign w_base      = ADDR_WIDTH'({C_ENG_NIB, init_addr[27:0]});
  assign w_beats     = mem_burst_size >> C_BEAT_SHIFT;
  assign w_rready    = dn_rdy & busy_q;
  assign w_r_hs      = m_axi_RVALID & w_rready;
  assign w_r_last_hs = w_r_hs & m_axi_RLAST;
  assign w_ar_hs     = arvalid_q & m_axi_ARREADY;
  assign unused_ok   = ^{m_axi_RID, init_addr[ADDR_WIDTH-1:28]};

`ifdef DDR3_CUSTOM_READ_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;
  logic [31:0] w_beat_xor;

  always_comb begin
    w_beat_xor = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) begin
      w_beat_xor = w_beat_xor ^ m_axi_RDATA[i*32 +: 32];
    end
  end

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == ST_IDLE && start_read) begin
      cksum_d = '0;
    end else if (w_r_hs) begin
      cksum_d = cksum_q ^ w_beat_xor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_err_d   = rd_err_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    ops_d      = ops_q;
    stride_d   = stride_q;
    ar_cnt_d   = ar_cnt_q;
    r_cnt_d    = r_cnt_q;
    beat_cnt_d = beat_cnt_q;

    // Return-path bookkeeping; RREADY is gated by busy so this is inert in IDLE.
    if (w_r_hs) begin
      if (m_axi_RLAST) begin
        r_cnt_d    = r_cnt_q + 32'd1;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
      if ((m_axi_RRESP != 2'b00) || (m_axi_RLAST != (beat_cnt_q == arlen_q))) begin
        rd_err_d = 1'b1;
      end
    end

    // A simultaneous AR accept and burst completion cancel out.
    outst_d = outst_q + 4'(w_ar_hs) - 4'(w_r_last_hs);

    // The running address advances only on acceptance, so ARADDR holds while stalled.
    if (w_ar_hs) begin
      ar_cnt_d = ar_cnt_q + 32'd1;
      araddr_d = araddr_q + ADDR_WIDTH'(stride_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          busy_d     = 1'b1;
          rd_err_d   = 1'b0;
          ops_d      = read_ops;
          stride_d   = stride;
          arlen_d    = 8'(w_beats - 16'd1);
          araddr_d   = w_base;
          ar_cnt_d   = '0;
          r_cnt_d    = '0;
          outst_d    = '0;
          beat_cnt_d = '0;
          if (read_ops == 32'd0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_cnt_d == ops_q) begin
          state_d   = ST_DRAIN;
          arvalid_d = 1'b0;
        end else begin
          // Once raised, this stays high until accepted: outstanding can only
          // fall while no AR handshake happens.
          arvalid_d = (outst_d < C_MAX_OUT);
        end
      end
      ST_DRAIN: begin
        arvalid_d = 1'b0;
        if (r_cnt_d == ops_q) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_err_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      ops_q      <= '0;
      stride_q   <= '0;
      ar_cnt_q   <= '0;
      r_cnt_q    <= '0;
      outst_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_err_q   <= rd_err_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      ops_q      <= ops_d;
      stride_q   <= stride_d;
      ar_cnt_q   <= ar_cnt_d;
      r_cnt_q    <= r_cnt_d;
      outst_q    <= outst_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rd_err         = rd_err_q;
  assign m_axi_ARVALID  = arvalid_q;
  assign m_axi_ARADDR   = araddr_q;
  assign m_axi_ARLEN    = arlen_q;
  assign m_axi_ARID     = '0;
  assign m_axi_ARSIZE   = C_AR_SIZE;
  assign m_axi_ARBURST  = 2'b01;
  assign m_axi_ARLOCK   = 2'b00;
  assign m_axi_ARCACHE  = 4'b0000;
  assign m_axi_ARPROT   = 3'b010;
  assign m_axi_ARQOS    = 4'd0;
  assign m_axi_ARREGION = 4'd0;
  assign m_axi_RREADY   = w_rready;
  assign dn_vld         = m_axi_RVALID & busy_q;
  assign dn_dat         = m_axi_RDATA;
  assign dn_last        = m_axi_RLAST;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_custom_read.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_custom_read
// Purpose  : Scoreboard bench for ddr3_custom_read (ENGINE_ID=2, 256-bit data,
//            MAX_OUTSTANDING=2). A small AXI slave returns address-derived
//            data; expected AR addresses and beats are queued at stimulus time
//            and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_custom_read;
  localparam int AW   = 33;
  localparam int DW   = 256;
  localparam int IW   = 5;
  localparam int MAXO = 2;

  logic          clk, rst;
  logic          start_read;
  logic [31:0]   read_ops, stride;
  logic [AW-1:0] init_addr;
  logic [15:0]   mem_burst_size;
  logic          busy, done, rd_err;
  logic          dn_vld, dn_last, dn_rdy;
  logic [DW-1:0] dn_dat;
  logic          ARVALID, ARREADY;
  logic [AW-1:0] ARADDR;
  logic [IW-1:0] ARID;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE, ARPROT;
  logic [1:0]    ARBURST, ARLOCK;
  logic [3:0]    ARCACHE, ARQOS, ARREGION;
  logic          RVALID, RLAST, RREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic [IW-1:0] RID;
`ifdef DDR3_CUSTOM_READ_CKSUM_EN
  logic [31:0]   cksum;
`endif

  ddr3_custom_read #(
    .ENGINE_ID(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start_read(start_read), .read_ops(read_ops), .stride(stride),
    .init_addr(init_addr), .mem_burst_size(mem_burst_size), .busy(busy), .done(done),
    .rd_err(rd_err), .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_last(dn_last), .dn_rdy(dn_rdy),
    .m_axi_ARVALID(ARVALID), .m_axi_ARADDR(ARADDR), .m_axi_ARID(ARID), .m_axi_ARLEN(ARLEN),
    .m_axi_ARSIZE(ARSIZE), .m_axi_ARBURST(ARBURST), .m_axi_ARLOCK(ARLOCK),
    .m_axi_ARCACHE(ARCACHE), .m_axi_ARPROT(ARPROT), .m_axi_ARQOS(ARQOS),
    .m_axi_ARREGION(ARREGION), .m_axi_ARREADY(ARREADY), .m_axi_RVALID(RVALID),
    .m_axi_RDATA(RDATA), .m_axi_RRESP(RRESP), .m_axi_RLAST(RLAST), .m_axi_RID(RID),
    .m_axi_RREADY(RREADY)
`ifdef DDR3_CUSTOM_READ_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat data: a scrambled byte address of each 32-bit lane.
  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int j);
    logic [DW-1:0] r;
    logic [31:0]   w;
    for (int k = 0; k < DW / 32; k++) begin
      w = a[31:0] + 32'(j * 32 + k * 4);
      r[k*32 +: 32] = (w * 32'h9E3779B1) ^ 32'h5A5A_0000;
    end
    return r;
  endfunction

  function automatic logic [31:0] lane_xor(input logic [DW-1:0] d);
    logic [31:0] x = '0;
    for (int k = 0; k < DW / 32; k++) x = x ^ d[k*32 +: 32];
    return x;
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [AW-1:0] exp_ar_q[$];
  beat_t         exp_r_q[$];
  logic [31:0]   exp_cksum;

  // Slave knobs and state
  int            ar_stall = 0, r_hold = 0, ar_wait = 0;
  bit            err_mode = 0, early_mode = 0, rdy_toggle = 0;
  logic [AW-1:0] sq[$];
  int            sb = 0, s_burst = 0, s_gbeat = 0, ar_hs_cnt = 0;
  bit            ar_hs_p = 0, r_hs_p = 0;
  logic [AW-1:0] ar_addr_p;

  // Monitor state
  int            done_cnt = 0, beats_seen = 0;
  bit            arv_seen = 0, prev_av = 0, prev_ar = 0;
  logic [AW-1:0] prev_addr;

  // AXI slave: acts on the handshakes predicted last cycle, then drives new values.
  initial begin
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = '0; dn_rdy = 1;
    forever begin
      @(negedge clk);
      if (ar_hs_p) begin
        sq.push_back(ar_addr_p);
        ar_wait = 0;
      end
      if (r_hs_p) begin
        if (RLAST) begin
          void'(sq.pop_front());
          sb = 0;
          s_burst++;
        end else begin
          sb++;
        end
        s_gbeat++;
      end
      if (ARVALID && ar_wait >= ar_stall) begin
        ARREADY = 1;
      end else begin
        ARREADY = 0;
        if (ARVALID) ar_wait++;
      end
      dn_rdy = rdy_toggle ? ~dn_rdy : 1'b1;
      if (r_hold > 0) begin
        r_hold--;
        RVALID = 0; RLAST = 0; RRESP = 0;
      end else if (sq.size() > 0) begin
        RVALID = 1;
        RDATA  = mkdata(sq[0], sb);
        RLAST  = (sb == 7) || (early_mode && s_burst == 0 && sb == 4);
        RRESP  = (err_mode && s_gbeat == 2) ? 2'b10 : 2'b00;
      end else begin
        RVALID = 0; RLAST = 0; RRESP = 0;
      end
      #1;
      ar_hs_p   = ARVALID & ARREADY;
      ar_addr_p = ARADDR;
      r_hs_p    = RVALID & RREADY;
      if (ar_hs_p) ar_hs_cnt++;
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t     b;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("rready_mirror", RREADY, dn_rdy & busy);
        chk("dn_vld", dn_vld, RVALID & busy);
        if (ARVALID) arv_seen = 1;
        if (prev_av && !prev_ar) begin
          chk("ar_hold_valid", ARVALID, 1'b1);
          chk("ar_hold_addr", ARADDR, prev_addr);
        end
        if (ARVALID && ARREADY) begin
          chk("ar_expected", exp_ar_q.size() > 0, 1'b1);
          if (exp_ar_q.size() > 0) begin
            ea = exp_ar_q.pop_front();
            chk("araddr", ARADDR, ea);
            chk("arlen", ARLEN, 8'd7);
            chk("ar_static", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION},
                {5'd0, 3'b101, 2'b01, 2'b00, 4'd0, 3'b010, 4'd0, 4'd0});
          end
        end
        if (dn_vld && dn_rdy) begin
          beats_seen++;
          chk("beat_expected", exp_r_q.size() > 0, 1'b1);
          if (exp_r_q.size() > 0) begin
            b = exp_r_q.pop_front();
            chk("dn_dat", dn_dat, b.d);
            chk("dn_last", dn_last, b.l);
          end
        end
        if (done) begin
          done_cnt++;
`ifdef DDR3_CUSTOM_READ_CKSUM_EN
          chk("cksum", cksum, exp_cksum);
`endif
        end
        prev_av   = ARVALID;
        prev_ar   = ARREADY;
        prev_addr = ARADDR;
      end else begin
        prev_av = 0;
      end
    end
  end

  task automatic run_op(input logic [31:0] ops, input logic [31:0] strd, input logic [27:0] base,
                        input bit exp_err, input int exp_beats);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            nb, d0;
    exp_cksum = '0;
    for (int i = 0; i < int'(ops); i++) begin
      a = 33'h0_2000_0000 + AW'(base) + AW'(i) * AW'(strd);
      exp_ar_q.push_back(a);
      nb = (early_mode && i == 0) ? 5 : 8;
      for (int j = 0; j < nb; j++) begin
        d = mkdata(a, j);
        exp_r_q.push_back('{d: d, l: (j == nb - 1)});
        exp_cksum = exp_cksum ^ lane_xor(d);
      end
    end
    read_ops = ops; stride = strd; init_addr = AW'(base); mem_burst_size = 16'd256;
    @(negedge clk);
    d0 = done_cnt; beats_seen = 0; ar_hs_cnt = 0; s_burst = 0; s_gbeat = 0;
    start_read = 1;
    @(negedge clk);
    start_read = 0;
    #3;
    chk("busy_after_start", busy, 1'b1);
    chk("rd_err_cleared", rd_err, 1'b0);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
    chk("done_seen", done_cnt != d0, 1'b1);
    repeat (2) @(negedge clk);
    #3;
    chk("done_once", done_cnt - d0, 1);
    chk("busy_end", busy, 1'b0);
    chk("rd_err_end", rd_err, exp_err);
    chk("beat_total", beats_seen, exp_beats);
    chk("r_queue_empty", exp_r_q.size(), 0);
    chk("ar_queue_empty", exp_ar_q.size(), 0);
    exp_r_q.delete();
    exp_ar_q.delete();
  endtask

  initial begin
    int d0;
    rst = 1; start_read = 0; read_ops = '0; stride = '0; init_addr = '0; mem_burst_size = 16'd256;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_araddr", ARADDR, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Basic: 4 bursts of 8 beats, AR stalled 2 cycles each to probe stability
    ar_stall = 2;
    run_op(32'd4, 32'h400, 28'h100, 1'b0, 32);
    ar_stall = 0;

    // Read data withheld: only MAX_OUTSTANDING bursts may be accepted
    r_hold = 50;
    fork
      run_op(32'd4, 32'h40, 28'h0AB_C000, 1'b0, 32);
      begin
        repeat (30) @(negedge clk);
        #3;
        chk("ar_hs_during_hold", ar_hs_cnt, 2);
        chk("arvalid_during_hold", ARVALID, 1'b0);
      end
    join

    // Downstream backpressure at 50%
    rdy_toggle = 1;
    run_op(32'd4, 32'h1000, 28'h0FF_FF00, 1'b0, 32);
    rdy_toggle = 0;

    // SLVERR on the third beat; error must persist after done
    err_mode = 1;
    run_op(32'd4, 32'h400, 28'h200, 1'b1, 32);
    err_mode = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("rd_err_sticky", rd_err, 1'b1);

    // Early RLAST on beat 5 of the first burst
    early_mode = 1;
    run_op(32'd4, 32'h400, 28'h300, 1'b1, 29);
    early_mode = 0;

    // Clean run clears the flag; single burst also gives a cksum check
    run_op(32'd1, 32'h0, 28'h0123_4560, 1'b0, 8);

    // read_ops = 0: done one cycle after start, no address phase
    exp_cksum = '0;
    arv_seen = 0;
    read_ops = '0;
    @(negedge clk);
    d0 = done_cnt;
    start_read = 1;
    @(negedge clk);
    start_read = 0;
    #3;
    chk("zero_ops_done", done, 1'b1);
    @(negedge clk);
    #3;
    chk("zero_ops_done_low", done, 1'b0);
    chk("zero_ops_done_cnt", done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    chk("zero_ops_no_arvalid", arv_seen, 1'b0);

    // Reset mid-ISSUE with the address channel stalled
    ar_stall = 1000;
    read_ops = 32'd4; stride = 32'h400; init_addr = 33'h100;
    @(negedge clk);
    start_read = 1;
    @(negedge clk);
    start_read = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("pre_rst_arvalid", ARVALID, 1'b1);
    d0 = done_cnt;
    rst = 1;
    #1;
    chk("async_rst_arvalid", ARVALID, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_araddr", ARADDR, '0);
    @(negedge clk);
    #3;
    rst = 0;
    ar_stall = 0;
    ar_wait = 0;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
